// File: rtl/ahb_master_pkg.sv
// Shared types and constants for the single-transfer AHB-Lite master engine.
package ahb_master_pkg;

   typedef enum logic [1:0] {
      TR_IDLE   = 2'b00,
      TR_NONSEQ = 2'b10
   } htrans_t;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [1:0] MODE_IDLE  = 2'b00;
   localparam logic [1:0] MODE_READ  = 2'b01;
   localparam logic [1:0] MODE_WRITE = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ADDR = 2'b01,
      S_DATA = 2'b10,
      S_ERR  = 2'b11
   } state_t;

   // size 11 is an alias for word
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == 2'b11) ? 2'b10 : size;
   endfunction

endpackage

// File: rtl/ahb_lane_align.sv
// Byte-lane steering: replicates narrow write data across the bus and
// extracts/zero-extends narrow read data from the addressed lane.
module ahb_lane_align
   import ahb_master_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] hrdata,
   output logic [31:0] wdata_lanes,
   output logic [31:0] rdata_ext
);

   // write replication and read lane extraction
   always_comb begin
      wdata_lanes = wdata;
      rdata_ext   = hrdata;
      case ({1'b0, size})
         HSIZE_BYTE: begin
            wdata_lanes = {4{wdata[7:0]}};
            case (addr_lo)
               2'b00:   rdata_ext = {24'h00_0000, hrdata[7:0]};
               2'b01:   rdata_ext = {24'h00_0000, hrdata[15:8]};
               2'b10:   rdata_ext = {24'h00_0000, hrdata[23:16]};
               2'b11:   rdata_ext = {24'h00_0000, hrdata[31:24]};
               default: rdata_ext = 32'h0000_0000;
            endcase
         end
         HSIZE_HALF: begin
            wdata_lanes = {2{wdata[15:0]}};
            if (addr_lo[1]) begin
               rdata_ext = {16'h0000, hrdata[31:16]};
            end else begin
               rdata_ext = {16'h0000, hrdata[15:0]};
            end
         end
         default: begin
            wdata_lanes = wdata;
            rdata_ext   = hrdata;
         end
      endcase
   end

endmodule

// File: rtl/ahb_master_engine.sv
// Single-transfer AHB-Lite master: one NONSEQ per request, feedback pulse on completion.
// Optional wait-state timeout enabled by defining AHB_TIMEOUT_EN.
module ahb_master_engine
   import ahb_master_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR0     = 32'h0000_0000,
   parameter logic [31:0] BASE_ADDR1     = 32'h0010_0000,
   parameter int          TIMEOUT_CYCLES = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mode,
   input  logic [19:0] pixNum,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic        startAddr_sel,
   output logic [31:0] rdata,
   output logic        data_feedback,
   output logic        err,
   output logic        busy,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   state_t      state;
   logic [1:0]  size_q;
   logic [31:0] wdata_q;
   logic [1:0]  sz_in;
   logic [31:0] addr_next;
   logic [31:0] wdata_lanes;
   logic [31:0] rdata_ext;
   logic        accept;
   logic        tmo_hit;

   assign HBURST = 3'b000;

   // request decode and address formation
   always_comb begin
      sz_in     = norm_size(size);
      addr_next = (startAddr_sel ? BASE_ADDR1 : BASE_ADDR0) + ({12'h000, pixNum} << sz_in);
      accept    = ((mode == MODE_READ) || (mode == MODE_WRITE)) && !data_feedback;
   end

   ahb_lane_align u_lane_align (
      .size        (size_q),
      .addr_lo     (HADDR[1:0]),
      .wdata       (wdata_q),
      .hrdata      (HRDATA),
      .wdata_lanes (wdata_lanes),
      .rdata_ext   (rdata_ext)
   );

`ifdef AHB_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   assign tmo_hit = (state != S_IDLE) && !HREADY && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

   // wait-state counter, cleared by any ready cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= 16'h0000;
      end else if ((state != S_IDLE) && !HREADY && !tmo_hit) begin
         tmo_cnt <= tmo_cnt + 16'h0001;
      end else begin
         tmo_cnt <= 16'h0000;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // transfer FSM with registered bus and handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         size_q        <= 2'b00;
         wdata_q       <= 32'h0000_0000;
         rdata         <= 32'h0000_0000;
         data_feedback <= 1'b0;
         err           <= 1'b0;
         busy          <= 1'b0;
         HADDR         <= 32'h0000_0000;
         HTRANS        <= TR_IDLE;
         HWRITE        <= 1'b0;
         HSIZE         <= 3'b000;
         HWDATA        <= 32'h0000_0000;
      end else begin
         data_feedback <= 1'b0;
         err           <= 1'b0;
         if (tmo_hit) begin
            HTRANS        <= TR_IDLE;
            data_feedback <= 1'b1;
            err           <= 1'b1;
            rdata         <= 32'h0000_0000;
            busy          <= 1'b0;
            state         <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (accept) begin
                     HADDR   <= addr_next;
                     HTRANS  <= TR_NONSEQ;
                     HWRITE  <= (mode == MODE_WRITE);
                     HSIZE   <= {1'b0, sz_in};
                     size_q  <= sz_in;
                     wdata_q <= wdata;
                     busy    <= 1'b1;
                     state   <= S_ADDR;
                  end
               end
               S_ADDR: begin
                  if (HREADY) begin
                     HTRANS <= TR_IDLE;
                     HWDATA <= HWRITE ? wdata_lanes : 32'h0000_0000;
                     state  <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (HREADY) begin
                     // a one-cycle ERROR is still reported as an error completion
                     if (HRESP) begin
                        rdata <= 32'h0000_0000;
                        err   <= 1'b1;
                     end else if (!HWRITE) begin
                        rdata <= rdata_ext;
                     end
                     data_feedback <= 1'b1;
                     busy          <= 1'b0;
                     state         <= S_IDLE;
                  end else if (HRESP) begin
                     state <= S_ERR;
                  end
               end
               S_ERR: begin
                  if (HREADY) begin
                     rdata         <= 32'h0000_0000;
                     data_feedback <= 1'b1;
                     err           <= 1'b1;
                     busy          <= 1'b0;
                     state         <= S_IDLE;
                  end
               end
               default: begin
                  HTRANS <= TR_IDLE;
                  busy   <= 1'b0;
                  state  <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
